// File: rtl/alu_seq.sv
// alu_seq: pipelined EX-stage ALU with valid/ready handshakes on both sides
// and a registered result. An optional iterative multiply/divide unit sits
// behind the macro ALU_MULDIV_EN.
//
// ALU_MULDIV_EN defined   : radix-2 shift-add multiply and restoring divide,
//                           WIDTH cycles per operation.
// ALU_MULDIV_EN undefined : ops 14-20 act as illegal ops (result 0 in one
//                           cycle), and busy is tied to 0.
//
// Ports
//   clk, rst_n          : clock (rising edge) and async active-low reset
//   flush               : synchronous squash of the in-flight op / held result
//   in_valid, in_ready  : request handshake (accepted on in_valid & in_ready)
//   op, a, b            : operation code and operands
//   out_valid, out_ready: result handshake
//   y                   : registered result
//   busy                : multiply/divide iteration in progress
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             busy
);

    localparam int M = WIDTH - 1;

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLTU = 5'd2,
                           OP_SLT  = 5'd3,  OP_AND  = 5'd4,  OP_OR   = 5'd5,
                           OP_NOR  = 5'd6,  OP_XOR  = 5'd7,  OP_SLL  = 5'd8,
                           OP_SRL  = 5'd9,  OP_SRA  = 5'd10, OP_SEQ  = 5'd11,
                           OP_SGEU = 5'd12, OP_SGE  = 5'd13;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_n;
    logic             accept;
    logic             y_load;
    logic [WIDTH-1:0] y_d;

    // ---------------- single-cycle datapath ----------------
    // One shared adder: everything except ADD computes a + ~b + 1.
    logic             sub, carry, ovf, slt;
    logic [WIDTH-1:0] b_sel, sum, alu_res;

    assign sub            = (op != OP_ADD);
    assign b_sel          = sub ? ~b : b;
    assign {carry, sum}   = {1'b0, a} + {1'b0, b_sel} + {{WIDTH{1'b0}}, sub};
    assign ovf            = (a[M] == b_sel[M]) && (sum[M] != a[M]);
    assign slt            = sum[M] ^ ovf;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        alu_res = '0;
        unique case (op)
            OP_ADD, OP_SUB: alu_res = sum;
            OP_SLTU:        alu_res = {{M{1'b0}}, ~carry};
            OP_SLT:         alu_res = {{M{1'b0}}, slt};
            OP_AND:         alu_res = a & b;
            OP_OR:          alu_res = a | b;
            OP_NOR:         alu_res = ~(a | b);
            OP_XOR:         alu_res = a ^ b;
            OP_SLL:         alu_res = a << b[SHW-1:0];
            OP_SRL:         alu_res = a >> b[SHW-1:0];
            OP_SRA:         alu_res = $signed(a) >>> b[SHW-1:0];
            OP_SEQ:         alu_res = {{M{1'b0}}, (sum == '0)};
            OP_SGEU:        alu_res = {{M{1'b0}}, carry};
            OP_SGE:         alu_res = {{M{1'b0}}, ~slt};
            default:        alu_res = '0;   // illegal (and muldiv when disabled)
        endcase
    end

`ifdef ALU_MULDIV_EN
    // ---------------- iterative multiply / divide ----------------
    localparam logic [4:0] OP_MUL  = 5'd14, OP_MULH = 5'd15, OP_MULHU = 5'd16,
                           OP_DIV  = 5'd17, OP_DIVU = 5'd18, OP_REM   = 5'd19,
                           OP_REMU = 5'd20;

    logic             is_md, md_start, is_signed, sa, sb, md_div;
    logic [WIDTH-1:0] hi, lo, opnd, hi_n, lo_n, md_res;
    logic [4:0]       md_op;
    logic             neg;
    logic [SHW-1:0]   cnt;
    logic [WIDTH:0]   mul_sum, div_sh;
    logic [2*WIDTH-1:0] prod;

    assign is_md     = (op >= OP_MUL) && (op <= OP_REMU);
    assign md_start  = accept & is_md;
    assign is_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign sa        = is_signed & a[M];
    assign sb        = is_signed & b[M];
    assign md_div    = (md_op >= OP_DIV);

    // hi:lo is the product accumulator (multiply) or remainder:dividend
    // (divide); opnd is the multiplicand or divisor magnitude.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_sh  = {hi, lo[M]};
        if (md_div) begin
            // A zero divisor always "fits", so the quotient becomes all ones
            // and the remainder ends up as the dividend magnitude.
            if (div_sh >= {1'b0, opnd}) begin
                hi_n = div_sh[M:0] - opnd;
                lo_n = {lo[M-1:0], 1'b1};
            end else begin
                hi_n = div_sh[M:0];
                lo_n = {lo[M-1:0], 1'b0};
            end
        end else begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], lo[M:1]};
        end
        prod = neg ? -{hi_n, lo_n} : {hi_n, lo_n};
        unique case (md_op)
            OP_MUL:            md_res = prod[WIDTH-1:0];
            OP_MULH, OP_MULHU: md_res = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:   md_res = neg ? -lo_n : lo_n;
            default:           md_res = neg ? -hi_n : hi_n;   // REM, REMU
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            md_op <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
        end else if (md_start) begin
            hi    <= '0;
            lo    <= sa ? -a : a;
            opnd  <= sb ? -b : b;
            md_op <= op;
            cnt   <= SHW'(WIDTH - 1);
            // Result sign: quotient sign excludes divide-by-zero so DIV x/0
            // stays all ones; remainder follows the dividend.
            unique case (op)
                OP_MULH: neg <= sa ^ sb;
                OP_DIV:  neg <= (sa ^ sb) & (b != '0);
                OP_REM:  neg <= sa;
                default: neg <= 1'b0;
            endcase
        end else if (state == BUSY) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (state == BUSY);
`else
    assign busy = 1'b0;
`endif

    // ---------------- control ----------------
    assign in_ready  = ~flush & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        y_load  = 1'b0;
        y_d     = alu_res;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
`ifdef ALU_MULDIV_EN
                    if (is_md) begin
                        state_n = BUSY;
                    end else
`endif
                    begin
                        state_n = DONE;
                        y_load  = 1'b1;
                    end
                end else if ((state == DONE) && out_ready) begin
                    state_n = IDLE;
                end
            end
`ifdef ALU_MULDIV_EN
            BUSY: begin
                if (cnt == '0) begin
                    state_n = DONE;
                    y_load  = 1'b1;
                    y_d     = md_res;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
        // Flush beats any accept or consume; y keeps its stale value.
        if (flush) begin
            state_n = IDLE;
            y_load  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      y <= '0;
        else if (y_load) y <= y_d;
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH = 32). Multiply/divide
// vectors run only when ALU_MULDIV_EN is defined; otherwise those ops are
// checked as illegal single-cycle ops returning 0.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        busy;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for its result, check value, latency and busy cycles,
    // then let it be consumed.
    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_y, input int exp_lat);
        int w, lat, bcnt;
        op = o; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin tick(); w++; end
        if (!in_ready) check({tag, " accept"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        lat = 0; bcnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        check(tag, 64'(y), 64'(exp_y));
        check({tag, " lat"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy"}, 64'(bcnt), 64'(exp_lat));
        tick();
    endtask

    localparam int MDL = 32;   // mul/div latency in edges after accept

    initial begin
        int seen;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        #12;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst busy",      64'(busy),      64'd0);
        check("rst y",         64'(y),         64'd0);
        check("rst in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // add / subtract / compares / logic
        run_op("add wrap", 5'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         0);
        run_op("sub",      5'd1,  32'd5,         32'd7,         32'hFFFF_FFFE, 0);
        run_op("slt",      5'd3,  32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         0);
        run_op("sltu",     5'd2,  32'h8000_0000, 32'h7FFF_FFFF, 32'd0,         0);
        run_op("sge",      5'd13, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1,         0);
        run_op("seq",      5'd11, 32'd5,         32'd5,         32'd1,         0);
        run_op("sgeu",     5'd12, 32'd3,         32'hFFFF_FFFF, 32'd0,         0);
        run_op("and",      5'd4,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 0);
        run_op("or",       5'd5,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 0);
        run_op("nor",      5'd6,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h000F_0000, 0);
        run_op("xor",      5'd7,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 0);

        // shifts
        run_op("sra",      5'd10, 32'h8000_0010, 32'h24,        32'hF800_0001, 0);
        run_op("srl",      5'd9,  32'h8000_0010, 32'h24,        32'h0800_0001, 0);
        run_op("sll",      5'd8,  32'h1,         32'd31,        32'h8000_0000, 0);
        run_op("illegal",  5'd25, 32'h1234,      32'h5678,      32'h0,         0);

`ifdef ALU_MULDIV_EN
        run_op("mulh",     5'd15, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, MDL);
        run_op("mul",      5'd14, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, MDL);
        run_op("mulhu",    5'd16, 32'hFFFF_FFFF, 32'd2,         32'h1,         MDL);
        run_op("divu0",    5'd18, 32'd7,         32'd0,         32'hFFFF_FFFF, MDL);
        run_op("rem0",     5'd19, 32'd7,         32'd0,         32'd7,         MDL);
        run_op("div ovf",  5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, MDL);
        run_op("rem ovf",  5'd19, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         MDL);
        run_op("div neg",  5'd17, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, MDL);
        run_op("rem neg",  5'd19, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, MDL);
        run_op("remu",     5'd20, 32'd100,       32'd7,         32'd2,         MDL);
`else
        run_op("add pre",  5'd0,  32'd3,         32'd4,         32'd7,         0);
        run_op("mul off",  5'd14, 32'd3,         32'd5,         32'd0,         0);
`endif

        // back-to-back single-cycle ops
        op = 5'd0; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a = 32'(i); b = 32'd10;
            tick();
            check("b2b y",     64'(y),         64'(i + 10));
            check("b2b valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        tick();

        // stall: result held while out_ready is low
        op = 5'd0; a = 32'd100; b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        a = 32'd200; b = 32'd2;
        for (int i = 0; i < 5; i++) begin
            check("hold y",        64'(y),         64'd101);
            check("hold valid",    64'(out_valid), 64'd1);
            check("hold in_ready", 64'(in_ready),  64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("release in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("release y",     64'(y),         64'd202);
        check("release valid", 64'(out_valid), 64'd1);
        tick();

        // flush of a held result beats a simultaneous accept and consume
        op = 5'd0; a = 32'd9; b = 32'd9; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        check("pre flush y", 64'(y), 64'd18);
        flush = 1'b1; a = 32'd1; b = 32'd1; out_ready = 1'b1;
        #1;
        check("flush in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush valid", 64'(out_valid), 64'd0);
        check("flush y",     64'(y),         64'd18);

`ifdef ALU_MULDIV_EN
        // flush in BUSY cycle 10
        op = 5'd14; a = 32'd6; b = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("busy c10", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("flush no result", 64'(seen), 64'd0);
`endif
        run_op("add post flush", 5'd0, 32'd2, 32'd3, 32'd5, 0);

        // async reset with a result pending (and mid-BUSY when muldiv exists)
        op = 5'd0; a = 32'd40; b = 32'd2; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("pre rst y", 64'(y), 64'd42);
        rst_n = 1'b0;
        #1;
        check("rst2 valid", 64'(out_valid), 64'd0);
        check("rst2 y",     64'(y),         64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
`ifdef ALU_MULDIV_EN
        run_op("add pre rst", 5'd0, 32'd1, 32'd1, 32'd2, 0);
        op = 5'd14; a = 32'd6; b = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("rst busy mid",  64'(busy),      64'd0);
        check("rst valid mid", 64'(out_valid), 64'd0);
        check("rst y mid",     64'(y),         64'd0);
        check("rst rdy mid",   64'(in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
`endif
        run_op("add after rst", 5'd0, 32'd2, 32'd3, 32'd5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, pipelined successor to the combinational CPU ALU: one registered result per accepted operation, valid/ready handshakes on both sides, and an optional iterative multiply/divide unit. It sits in the EX stage of the pipeline CPU. The pipeline stalls on `in_ready`/`out_valid` instead of assuming a single-cycle result. Relative to the previous ALU, signed compare and arithmetic right shift are made exact, and `flush` lets the pipeline squash an in-flight operation.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 8 and a power of two.
- `SHW`, `$clog2(WIDTH)`: shift-amount width. The shift amount is `b[SHW-1:0]`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `flush` input 1: synchronous squash of the operation in flight and of any held result.
- `in_valid` input 1: operation request.
- `in_ready` output 1: request accepted on the same edge where `in_valid & in_ready` is high.
- `op` input 5: encoded operation, listed under Operation.
- `a`, `b` input `WIDTH`: operands.
- `out_valid` output 1: `y` holds a result.
- `out_ready` input 1: consumer takes the result.
- `y` output `WIDTH`: registered result.
- `busy` output 1: multiply/divide iteration in progress.

## Operation
- **Op codes:**
  - 0 ADD, 1 SUB.
  - 2 SLTU, 3 SLT. SLT is a true signed compare: `sum[MSB] ^ overflow`.
  - 4 AND, 5 OR, 6 NOR, 7 XOR.
  - 8 SLL, 9 SRL, 10 SRA. SRA shifts `a` as signed, so the sign bit fills.
  - 11 SEQ, 12 SGEU, 13 SGE.
  - 14 MUL (low half), 15 MULH (signed×signed, high half), 16 MULHU (unsigned high half).
  - 17 DIV, 18 DIVU, 19 REM, 20 REMU.
  - 21–31 are illegal and return 0 with single-cycle latency.
- **Compare results:** 0 or 1, zero-extended to `WIDTH`.
- **Add/subtract:** one shared `WIDTH`-bit adder. SUB and all compares use `a + ~b + 1`.
- **FSM states:** IDLE, BUSY, DONE.
  - IDLE, accept of op 0–13 or an illegal op → DONE, with `y` loaded with the result.
  - IDLE, accept of op 14–20 → BUSY. On entry, operands are latched as magnitudes, the result sign is recorded, and the iteration counter is set to `WIDTH-1`.
  - BUSY: one radix-2 step per cycle (shift-add for multiply, restoring division for divide). When the counter reaches 0, the sign-corrected result is written to `y` → DONE.
  - DONE with `out_ready` → IDLE, or straight to the next operation if one is accepted on the same cycle.
- **Divide special cases:**
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → `a`.
  - Signed overflow (DIV of `-2^(WIDTH-1)` by `-1`): quotient `-2^(WIDTH-1)`, remainder 0.
  - Both special cases still take the full `WIDTH` cycles, so latency is data-independent.
- **`in_ready`:** equals `~flush & (state==IDLE | (state==DONE & out_ready))`, giving back-to-back throughput for single-cycle ops.
- **Flush:** `flush` → IDLE. `out_valid` and `busy` drop on the next edge. `y` holds its stale value. Flush wins over a simultaneous accept or consume.
- **Mid-operation reset:** async reset in any state → IDLE immediately. No partial result is output.

## Timing
- **Reset values:** `out_valid`=0, `busy`=0, `y`=0, state IDLE. `in_ready`=1 after reset with `flush` low.
- **Single-cycle ops:** accept on edge N → `out_valid`=1 and `y` valid after edge N (visible in cycle N+1).
- **Mul/div:** accept on edge N → `busy`=1 in cycles N+1 … N+`WIDTH`. `out_valid`=1 from cycle N+`WIDTH`+1.
- **Holding:** `y` and `out_valid` are stable while `out_valid & ~out_ready`. No result is ever overwritten or dropped.
- **`in_ready` during BUSY:** 0.

## Configuration
- **`ALU_MULDIV_EN` defined:** iterative multiply/divide datapath, BUSY state and the `busy` output are present.
- **`ALU_MULDIV_EN` undefined:**
  - Ops 14–20 behave as illegal ops: result 0, single-cycle latency.
  - BUSY is unreachable and `busy` is tied to 0.
  - No multiply/divide registers are synthesised.

## Test plan
- **Add/subtract and compares:** `WIDTH`=32, ADD `0xFFFFFFFF`+1 → `y`=0, one cycle later. SLT `0x80000000`,`0x7FFFFFFF` → 1. SLTU of the same operands → 0. SGE `0x7FFFFFFF`,`0x80000000` → 1.
- **Shifts:**
  - SRA `0x80000010` by `b`=`0x24` (amount 4) → `0xF8000001`.
  - SRL of the same → `0x08000001`.
  - SLL 1 by 31 → `0x80000000`.
- **Multiply** (`ALU_MULDIV_EN` defined):
  - MULH −3×5 → `0xFFFFFFFF`.
  - MUL of the same → `0xFFFFFFF1`.
  - MULHU `0xFFFFFFFF`×2 → 1.
  - `busy` high exactly 32 cycles, `out_valid` at accept+33.
- **Divide specials:**
  - DIVU 7/0 → `0xFFFFFFFF`; REM 7/0 → 7.
  - DIV `0x80000000`/−1 → `0x80000000`; REM of the same → 0.
  - DIV −7/2 → −3; REM −7/2 → −1.
- **Handshake:**
  - Back-to-back ADDs with `out_ready`=1 → one result per cycle.
  - `out_ready`=0 for 5 cycles → `y` stable and `in_ready`=0. Release → next op accepted on the release cycle.
- **Flush and reset:**
  - `flush` at BUSY cycle 10 → IDLE, `out_valid` never asserts, next ADD 2+3 → 5.
  - `rst_n` low mid-BUSY → all outputs at reset values immediately.
  - With the macro undefined, MUL → 0 after one cycle.
